// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: latches one CPU access, inserts WAIT_CYCLES
// wait states, then acknowledges for one cycle with read data or a fault flag.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  WC_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] mem [DEPTH];

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_fault;
    logic        commit;

    // In IDLE the access being accepted is still on the inputs; afterwards it is latched.
    always_comb begin
        acc_we    = (state_q == S_IDLE) ? we    : we_q;
        acc_addr  = (state_q == S_IDLE) ? addr  : addr_q;
        acc_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
        acc_fault = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W);
        commit    = reset && acc_we && !acc_fault &&
                    (state_d == S_ACK) && (state_q != S_ACK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACK;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WC_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[acc_addr[IW+1:2]] <= acc_wdata;
        end
    end

    always_comb begin
        ack   = (state_q == S_ACK);
        err   = ack && acc_fault;
        busy  = (state_q != S_IDLE);
        rdata = (ack && !acc_fault && !we_q) ? mem[addr_q[IW+1:2]] : '0;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit storage words.
REQ-002 Parameter WAIT_CYCLES, default 2, legal 0..15: wait states inserted before each acknowledge.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  CPU access request, held high by the CPU until ack is seen.
REQ-006 we  input  1  1 = write access, 0 = read access; sampled with req.
REQ-007 addr  input  32  byte address, word-aligned (addr[1:0] = 0), word index addr[31:2].
REQ-008 wdata  input  32  write data; sampled with req.
REQ-009 ack  output  1  one-cycle acknowledge completing the current access.
REQ-010 err  output  1  access fault, valid only while ack = 1.
REQ-011 rdata  output  32  read data, valid only while ack = 1 and err = 0.
REQ-012 busy  output  1  high while an accepted access is in progress (WAIT or ACK state).

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, WAIT, ACK.
REQ-014 In IDLE with req = 1 at a rising edge, the block SHALL latch we, addr and wdata.
REQ-015 From that IDLE acceptance, the FSM SHALL go to WAIT when WAIT_CYCLES > 0, or directly to ACK when WAIT_CYCLES = 0.
REQ-016 On entering WAIT, the wait counter SHALL load WAIT_CYCLES-1.
REQ-017 Each WAIT cycle, the wait counter SHALL decrement; WAIT SHALL go to ACK on the edge where the counter is 0.
REQ-018 ack SHALL be high for exactly one cycle (the ACK state), i.e. WAIT_CYCLES+1 cycles after the edge that accepted req.
REQ-019 ACK SHALL always go to IDLE on the next edge.
REQ-020 A req still high in the IDLE cycle following ACK SHALL be accepted as a new access, giving back-to-back access spacing of WAIT_CYCLES+2 cycles.
REQ-021 Changes on req, we, addr or wdata during WAIT or ACK SHALL be ignored; the latched values govern the access.
REQ-022 A fault SHALL be flagged when the latched addr[1:0] != 0 (misaligned) or the latched addr[31:2] >= DEPTH (out of range).
REQ-023 For a non-faulting write, mem[addr[31:2]] SHALL be updated on the edge entering ACK.
REQ-024 For a faulting write, memory SHALL be left unmodified.
REQ-025 For a non-faulting read, rdata SHALL present mem[addr[31:2]] during ACK.
REQ-026 A read in the cycle after a write to the same word SHALL return the newly written value (no stale data).
REQ-027 err SHALL be 1 during ACK for a faulting access and 0 at all other times.
REQ-028 For a faulting access, rdata SHALL be 0.
REQ-029 rdata SHALL be 0 whenever ack = 0.
REQ-030 busy SHALL be 1 in WAIT and ACK, and 0 in IDLE.
REQ-031 The wait counter SHALL be 4 bits wide and SHALL never wrap below 0.

Reset
REQ-032 reset = 0 SHALL immediately, without waiting for clk, force IDLE, ack = 0, err = 0, rdata = 0, busy = 0, wait counter = 0 and clear the latched request.
REQ-033 Reset asserted during WAIT SHALL abort the access; a pending write SHALL NOT be committed.
REQ-034 Memory contents SHALL NOT be cleared by reset.
REQ-035 After reset is released, the first rising edge with req = 1 SHALL be a normal IDLE acceptance.

Verification (DEPTH = 256, WAIT_CYCLES = 2 unless stated)
REQ-036 Write/read: write 0xDEADBEEF to addr 0x10, then read addr 0x10 -> read ack arrives 3 cycles after acceptance, rdata = 0xDEADBEEF, err = 0.
REQ-037 Faults: read addr 0x402 -> err = 1, rdata = 0; write 0x12345678 to addr 0x400 -> err = 1, and a later read of 0x000 still returns its prior value.
REQ-038 Back-to-back: req held high for 3 accesses -> ack pulses exactly 4 cycles apart, each 1 cycle wide.
REQ-039 Reset mid-operation: assert reset during the WAIT of a write of 0xA5A5A5A5 to 0x20 -> ack, busy and rdata drop at once; a subsequent read of 0x20 returns the old value.
REQ-040 WAIT_CYCLES = 0: read of addr 0x04 -> ack in the cycle after acceptance; addr changed during ACK has no effect.
